i2c_codec_responder: RTL and testbench
======================================

# i2c_codec_responder

I2C target that models the audio codec's control port. It watches the bus driven by the codec configuration master, acknowledges 3-byte writes (device byte 0x34, then two data bytes), and decodes each 16-bit word into a 7-bit register address and 9-bit register data. It keeps a 16-entry shadow register file that the rest of the design and the testbench can read back. It sits on the same SCLK/SDIN pair as the configuration master, either in simulation or inside the FPGA as a configuration monitor.

## Interface
Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address; the write device byte is 0x34.
- MIN_PHASE, 8, minimum SCLK high/low time in clk cycles that the block guarantees to handle.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- scl_in  in  1  bus SCLK, asynchronous to clk.
- sda_in  in  1  bus SDIN as seen on the wire, asynchronous to clk.
- sda_drive_low  out  1  1 = pull SDIN low. The top level forms the open-drain driver: SDIN = sda_drive_low ? 0 : z.
- word  out  16  last accepted word {reg_addr[6:0], reg_data[8:0]}.
- word_valid  out  1  one-clk pulse when a word is committed.
- addr_err  out  1  one-clk pulse when a word with reg_addr > 0x0F completes.
- busy  out  1  high from START until STOP.
- rd_addr  in  4  shadow register read index.
- rd_data  out  9  combinational read of shadow[rd_addr].
- write_count  out  8  number of committed words; wraps 255→0.

## Operation
- **Synchronisers:** scl_in and sda_in each pass through a 2-flop synchroniser. Edges are detected on the synchronised values by comparing against a third registered copy.
- **START:** SDA falls while SCL is high. Legal in any state, including as a repeated START. Action: bit_cnt←0, go to ADDR, busy←1.
- **STOP:** SDA rises while SCL is high. Action: go to IDLE, sda_drive_low←0, busy←0. A STOP in any state aborts the frame without commit.
- **Bit sampling:** each data bit is sampled on the SCL rising edge, MSB first. SDA changes while SCL is high are treated only as START/STOP.
- **States:**
  - IDLE: wait for START.
  - ADDR: receive 8 bits. After the 8th bit, compare with {DEV_ADDR,1'b0}. On a match, go to ACK_A. On a mismatch or R/W=1, go to IGNORE.
  - ACK_A: assert sda_drive_low at the SCL falling edge that ends bit 8. Release it at the next SCL falling edge (end of the 9th clock), then go to BYTE1.
  - BYTE1: receive word[15:8], then go to ACK_1 (same ACK timing as ACK_A), then BYTE2.
  - BYTE2: receive word[7:0], then go to ACK_2. At the falling edge that releases ACK_2, commit and go to WAIT_STOP.
  - WAIT_STOP: never ACK further bytes; wait for STOP or START.
  - IGNORE: never drive SDA; wait for STOP or START.
- **Commit** happens in one clk:
  - word←received word; word_valid pulses; write_count increments.
  - If reg_addr ≤ 0x0F: shadow[reg_addr[3:0]]←reg_data.
  - Otherwise: addr_err pulses and the shadow file is unchanged.
  - Writing reg 0x0F (codec reset) with any data clears shadow[0..14] to 0 and stores the data in shadow[15].
- **Reset:** the shadow file clears to 0.

## Timing
- **Reset values:** sda_drive_low 0, word 0, word_valid 0, addr_err 0, busy 0, write_count 0, state IDLE, shadow all 0.
- **Reset mid-frame:** the next cycle returns to IDLE with SDA released, and no commit occurs. The block ignores the bus until the next START.
- **Bus-edge latency:** sda_drive_low changes exactly 3 clk after the corresponding scl_in falling edge (2 synchroniser stages plus 1 detect stage).
- **Commit latency:** word_valid asserts 4 clk after the scl_in falling edge that ends the ACK_2 clock.
- **Bus timing:** correct for any SCLK high/low phase ≥ MIN_PHASE clk, and for SDA transitions ≥ 4 clk away from SCL edges.
- **Simultaneous events:** if START/STOP is detected in the same cycle as an SCL edge, START/STOP wins.
- **Pulse width:** word_valid and addr_err are never high for more than 1 cycle.

## Test plan
- **Normal write:** START, 0x34, 0x0A, 0x12, STOP → ACK low on clocks 9/18/27; word=0x0A12; word_valid pulses once; rd_addr=5 gives rd_data=0x012; write_count=1.
- **Wrong device:** device byte 0x36 then 2 bytes → sda_drive_low never asserts; no word_valid; shadow unchanged.
- **Read bit set:** device byte 0x35 → no ACK; block goes to IGNORE; busy stays 1 until STOP.
- **Out-of-range register:** 0x34, 0x40, 0x01 (reg_addr 0x20) → all three ACKs given; addr_err pulses; word_valid pulses; shadow unchanged.
- **Codec reset register:** write reg 3 = 0x1FF, then word 0x1E00 → shadow[3]=0, shadow[15]=0; write_count=2.
- **Aborts:** repeated START after BYTE1, then a full write of 0x0C05 → only 0x0C05 is committed. Separately, reset asserted during BYTE2 → sda_drive_low=0 next cycle and no commit.

Source files
------------

// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the audio codec control port: acknowledges
// 3-byte writes to DEV_ADDR and mirrors registers 0x00-0x0F in a shadow file.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MIN_PHASE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_drive_low,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        addr_err,
  output logic        busy,
  input  logic [3:0]  rd_addr,
  output logic [8:0]  rd_data,
  output logic [7:0]  write_count
);

  // Synchroniser plus detect stage eats 3 clk; shorter bus phases would alias.
  if (MIN_PHASE < 4) begin : g_phase_check
    $error("MIN_PHASE must be at least 4 clk");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP, IGNORE
  } state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [15:0] word_rx;
  logic        commit_pend;
  logic [8:0]  shadow [16];

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // NOTE: synchronisers keep tracking the bus during reset so that releasing
  // reset mid-frame cannot fabricate an edge or a START from stale flops.
  always_ff @(posedge clk) begin
    scl_s1 <= scl_in;
    scl_s2 <= scl_s1;
    scl_d  <= scl_s2;
    sda_s1 <= sda_in;
    sda_s2 <= sda_s1;
    sda_d  <= sda_s2;
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign rd_data = shadow[rd_addr];

  // NOTE: the shadow file lives in flops (not RAM) because it must clear in
  // one cycle on reset and on a codec-reset write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      word_rx       <= '0;
      commit_pend   <= 1'b0;
      sda_drive_low <= 1'b0;
      busy          <= 1'b0;
      word          <= '0;
      word_valid    <= 1'b0;
      addr_err      <= 1'b0;
      write_count   <= '0;
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else begin
      word_valid  <= 1'b0;
      addr_err    <= 1'b0;
      commit_pend <= 1'b0;

      if (commit_pend) begin
        word        <= word_rx;
        word_valid  <= 1'b1;
        write_count <= write_count + 8'd1;
        if (word_rx[15:9] == 7'h0F) begin
          for (int i = 0; i < 15; i++) shadow[i] <= '0;
          shadow[15] <= word_rx[8:0];
        end else if (word_rx[15:13] == 3'b000) begin
          shadow[word_rx[12:9]] <= word_rx[8:0];
        end else begin
          addr_err <= 1'b1;
        end
      end

      // Bus conditions outrank any SCL edge seen in the same cycle.
      if (start_det) begin
        state         <= ADDR;
        bit_cnt       <= '0;
        busy          <= 1'b1;
        sda_drive_low <= 1'b0;
      end else if (stop_det) begin
        state         <= IDLE;
        busy          <= 1'b0;
        sda_drive_low <= 1'b0;
      end else begin
        unique case (state)
          ADDR, BYTE1, BYTE2: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (shreg == {DEV_ADDR, 1'b0}) begin
                  state         <= ACK_A;
                  sda_drive_low <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end else if (state == BYTE1) begin
                word_rx[15:8] <= shreg;
                state         <= ACK_1;
                sda_drive_low <= 1'b1;
              end else begin
                word_rx[7:0]  <= shreg;
                state         <= ACK_2;
                sda_drive_low <= 1'b1;
              end
            end
          end
          ACK_A, ACK_1, ACK_2: begin
            if (scl_fall) begin
              sda_drive_low <= 1'b0;
              unique case (state)
                ACK_A:   state <= BYTE1;
                ACK_1:   state <= BYTE2;
                default: begin
                  state       <= WAIT_STOP;
                  commit_pend <= 1'b1;
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: a bit-banged bus master drives
// frames and each task checks ACKs, commits and the shadow file inline.
module tb_i2c_codec_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        sda_m;
  logic        sda_w;
  logic        sda_drive_low;
  logic [15:0] word;
  logic        word_valid;
  logic        addr_err;
  logic        busy;
  logic [3:0]  rd_addr;
  logic [8:0]  rd_data;
  logic [7:0]  write_count;

  int checks = 0;
  int errors = 0;

  int wv_count = 0;
  int ae_count = 0;
  int drive_cycles = 0;
  int wide_pulses = 0;
  logic wv_prev = 1'b0;
  logic ae_prev = 1'b0;

  assign sda_w = sda_m & ~sda_drive_low;

  i2c_codec_responder dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (scl),
    .sda_in       (sda_w),
    .sda_drive_low(sda_drive_low),
    .word         (word),
    .word_valid   (word_valid),
    .addr_err     (addr_err),
    .busy         (busy),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .write_count  (write_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid) wv_count++;
    if (addr_err) ae_count++;
    if (sda_drive_low) drive_cycles++;
    if ((word_valid && wv_prev) || (addr_err && ae_prev)) wide_pulses++;
    wv_prev = word_valid;
    ae_prev = addr_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(5);  sda_m = 1'b1;
    wait_clk(15); scl = 1'b1;
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(5);  sda_m = 1'b0;
    wait_clk(15); scl = 1'b1;
    wait_clk(10); sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(5);  sda_m = b;
    wait_clk(15); scl = 1'b1;
    wait_clk(20); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic ack_clock(output logic acked);
    wait_clk(5);  sda_m = 1'b1;
    wait_clk(15); scl = 1'b1;
    wait_clk(10); acked = (sda_w === 1'b0);
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] dev, input logic [7:0] b1,
                             input logic [7:0] b2, output logic [2:0] acks);
    bus_start();
    send_byte(dev); ack_clock(acks[2]);
    send_byte(b1);  ack_clock(acks[1]);
    send_byte(b2);  ack_clock(acks[0]);
    bus_stop();
  endtask

  task automatic read_shadow(input logic [3:0] a, output logic [8:0] d);
    @(negedge clk);
    rd_addr = a;
    #1 d = rd_data;
  endtask

  task automatic test_reset();
    logic [8:0] d;
    reset = 1'b0; scl = 1'b1; sda_m = 1'b1; rd_addr = '0;
    wait_clk(6);
    checks++;
    if ({sda_drive_low, word_valid, addr_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b required 0000",
                         {sda_drive_low, word_valid, addr_err, busy});
    end
    checks++;
    if (word !== 16'h0000 || write_count !== 8'd0) begin
      errors++; $display("FAIL reset_word_count: got %h/%0d required 0000/0", word, write_count);
    end
    for (int i = 0; i < 16; i++) begin
      read_shadow(i[3:0], d);
      checks++;
      if (d !== 9'h000) begin
        errors++; $display("FAIL reset_shadow[%0d]: got %h required 000", i, d);
      end
    end
    @(negedge clk) reset = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_normal_write();
    logic a0, a1, a2;
    logic [8:0] d;
    int wv0 = wv_count;
    bus_start();
    wait_clk(5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL normal_busy_start: got %b required 1", busy);
    end
    send_byte(8'h34);
    repeat (2) @(posedge clk);
    #1 checks++;
    if (sda_drive_low !== 1'b0) begin
      errors++; $display("FAIL ack_latency_early: got %b required 0 at 2 clk", sda_drive_low);
    end
    @(posedge clk);
    #1 checks++;
    if (sda_drive_low !== 1'b1) begin
      errors++; $display("FAIL ack_latency: got %b required 1 at 3 clk", sda_drive_low);
    end
    ack_clock(a2);
    send_byte(8'h0A); ack_clock(a1);
    send_byte(8'h12); ack_clock(a0);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL commit_latency_early: got %b required 0 at 3 clk", word_valid);
    end
    @(posedge clk);
    #1 checks++;
    if (word_valid !== 1'b1 || word !== 16'h0A12) begin
      errors++; $display("FAIL commit_latency: got valid=%b word=%h required 1/0a12", word_valid, word);
    end
    bus_stop();
    checks++;
    if ({a2, a1, a0} !== 3'b111) begin
      errors++; $display("FAIL normal_acks: got %b required 111", {a2, a1, a0});
    end
    checks++;
    if (wv_count - wv0 !== 1) begin
      errors++; $display("FAIL normal_wv_count: got %0d required 1", wv_count - wv0);
    end
    checks++;
    if (busy !== 1'b0 || write_count !== 8'd1) begin
      errors++; $display("FAIL normal_busy_count: got %b/%0d required 0/1", busy, write_count);
    end
    read_shadow(4'd5, d);
    checks++;
    if (d !== 9'h012) begin
      errors++; $display("FAIL normal_shadow5: got %h required 012", d);
    end
  endtask

  task automatic test_wrong_device();
    logic [2:0] acks;
    logic [8:0] d;
    int wv0 = wv_count;
    int dr0 = drive_cycles;
    write_frame(8'h36, 8'h0A, 8'h34, acks);
    checks++;
    if (drive_cycles - dr0 !== 0 || acks !== 3'b000) begin
      errors++; $display("FAIL wrong_dev_ack: got %0d drive cycles acks %b required 0/000",
                         drive_cycles - dr0, acks);
    end
    checks++;
    if (wv_count - wv0 !== 0 || write_count !== 8'd1) begin
      errors++; $display("FAIL wrong_dev_commit: got %0d pulses count %0d required 0/1",
                         wv_count - wv0, write_count);
    end
    read_shadow(4'd5, d);
    checks++;
    if (d !== 9'h012) begin
      errors++; $display("FAIL wrong_dev_shadow5: got %h required 012", d);
    end
  endtask

  task automatic test_read_bit();
    logic a;
    bus_start();
    send_byte(8'h35); ack_clock(a);
    send_byte(8'h00);
    checks++;
    if (a !== 1'b0) begin
      errors++; $display("FAIL read_bit_ack: got %b required 0", a);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL read_bit_busy: got %b required 1", busy);
    end
    bus_stop();
    checks++;
    if (busy !== 1'b0 || write_count !== 8'd1) begin
      errors++; $display("FAIL read_bit_stop: got busy %b count %0d required 0/1", busy, write_count);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] acks;
    logic [8:0] d;
    int wv0 = wv_count;
    int ae0 = ae_count;
    write_frame(8'h34, 8'h40, 8'h01, acks);
    checks++;
    if (acks !== 3'b111) begin
      errors++; $display("FAIL oor_acks: got %b required 111", acks);
    end
    checks++;
    if (ae_count - ae0 !== 1 || wv_count - wv0 !== 1) begin
      errors++; $display("FAIL oor_pulses: got ae %0d wv %0d required 1/1",
                         ae_count - ae0, wv_count - wv0);
    end
    checks++;
    if (word !== 16'h4001 || write_count !== 8'd2) begin
      errors++; $display("FAIL oor_word: got %h/%0d required 4001/2", word, write_count);
    end
    read_shadow(4'd5, d);
    checks++;
    if (d !== 9'h012) begin
      errors++; $display("FAIL oor_shadow5: got %h required 012", d);
    end
    read_shadow(4'd0, d);
    checks++;
    if (d !== 9'h000) begin
      errors++; $display("FAIL oor_shadow0: got %h required 000", d);
    end
  endtask

  task automatic test_codec_reset();
    logic [2:0] acks;
    logic [8:0] d;
    int ae0 = ae_count;
    write_frame(8'h34, 8'h07, 8'hFF, acks);
    read_shadow(4'd3, d);
    checks++;
    if (d !== 9'h1FF) begin
      errors++; $display("FAIL creset_pre_shadow3: got %h required 1ff", d);
    end
    write_frame(8'h34, 8'h1E, 8'h00, acks);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] idx;
      idx = (i == 0) ? 4'd3 : (i == 1) ? 4'd5 : 4'd15;
      read_shadow(idx, d);
      checks++;
      if (d !== 9'h000) begin
        errors++; $display("FAIL creset_shadow[%0d]: got %h required 000", idx, d);
      end
    end
    write_frame(8'h34, 8'h1E, 8'hAB, acks);
    read_shadow(4'd15, d);
    checks++;
    if (d !== 9'h0AB) begin
      errors++; $display("FAIL creset_shadow15: got %h required 0ab", d);
    end
    checks++;
    if (write_count !== 8'd5 || ae_count - ae0 !== 0) begin
      errors++; $display("FAIL creset_count: got %0d ae %0d required 5/0", write_count, ae_count - ae0);
    end
  endtask

  task automatic test_repeated_start();
    logic a;
    logic [2:0] acks;
    logic [8:0] d;
    int wv0 = wv_count;
    bus_start();
    send_byte(8'h34); ack_clock(a);
    send_byte(8'h11); ack_clock(a);
    write_frame(8'h34, 8'h0C, 8'h05, acks);
    checks++;
    if (wv_count - wv0 !== 1 || word !== 16'h0C05 || acks !== 3'b111) begin
      errors++; $display("FAIL rstart_commit: got %0d pulses word %h acks %b required 1/0c05/111",
                         wv_count - wv0, word, acks);
    end
    read_shadow(4'd6, d);
    checks++;
    if (d !== 9'h005 || write_count !== 8'd6) begin
      errors++; $display("FAIL rstart_shadow6: got %h count %0d required 005/6", d, write_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic a;
    logic [8:0] d;
    int wv0 = wv_count;
    bus_start();
    send_byte(8'h34); ack_clock(a);
    send_byte(8'h02); ack_clock(a);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 checks++;
    if (sda_drive_low !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_release: got drive %b busy %b required 0/0", sda_drive_low, busy);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ack_clock(a);
    checks++;
    if (a !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_ignore: got ack %b busy %b required 0/0", a, busy);
    end
    bus_stop();
    checks++;
    if (wv_count - wv0 !== 0 || write_count !== 8'd0 || word !== 16'h0000) begin
      errors++; $display("FAIL midreset_commit: got %0d pulses count %0d word %h required 0/0/0000",
                         wv_count - wv0, write_count, word);
    end
    read_shadow(4'd6, d);
    checks++;
    if (d !== 9'h000) begin
      errors++; $display("FAIL midreset_shadow6: got %h required 000", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] acks;
    logic [8:0] d;
    write_frame(8'h34, 8'h03, 8'h55, acks);
    write_frame(8'h34, 8'h04, 8'hAA, acks);
    read_shadow(4'd1, d);
    checks++;
    if (d !== 9'h155) begin
      errors++; $display("FAIL b2b_shadow1: got %h required 155", d);
    end
    read_shadow(4'd2, d);
    checks++;
    if (d !== 9'h0AA || write_count !== 8'd2) begin
      errors++; $display("FAIL b2b_shadow2: got %h count %0d required 0aa/2", d, write_count);
    end
    checks++;
    if (wide_pulses !== 0) begin
      errors++; $display("FAIL pulse_width: got %0d wide pulses required 0", wide_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_normal_write();
    test_wrong_device();
    test_read_bit();
    test_out_of_range();
    test_codec_reset();
    test_repeated_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
